// File: rtl/jesd204_tx_if.sv
// -----------------------------------------------------------------------------
// jesd204_tx_if
// Bundles the static link configuration, the user data word, the lane data
// word and the receiver-side control strobes of the JESD204B transmit link
// layer.
//   master : sample/transport side (drives configuration, DI, SYNC_n, SYSREF)
//   slave  : the link layer itself (drives DO, RDY)
// Configuration fields are ILAS-encoded (value minus one where JESD204B
// defines it so) and are expected to stay static while the link runs.
// -----------------------------------------------------------------------------
interface jesd204_tx_if;
    logic [3:0]      ADJCNT;
    logic            ADJDIR;
    logic [3:0]      BID;
    logic [4:0]      CF;
    logic [1:0]      CS;
    logic [7:0]      DID;
    logic [7:0]      F;
    logic            HD;
    logic [2:0]      JESDV;
    logic [4:0]      K;
    logic [4:0]      L;
    logic [4:0]      LID;
    logic [7:0]      M;
    logic [4:0]      N;
    logic [4:0]      N_;
    logic            PHADJ;
    logic [4:0]      S;
    logic            SCR;
    logic [2:0]      SUBCLASSV;
    logic [7:0]      RES1;
    logic [7:0]      RES2;
    logic [7:0]      CHKSUM;
    logic            RDY;
    logic [3:0][7:0] DI;
    logic [3:0][7:0] DO;
    logic            SYNC_n;
    logic            SYSREF;

    modport master (
        output ADJCNT, ADJDIR, BID, CF, CS, DID, F, HD, JESDV, K, L, LID, M, N,
               N_, PHADJ, S, SCR, SUBCLASSV, RES1, RES2, CHKSUM, DI, SYNC_n,
               SYSREF,
        input  RDY, DO
    );

    modport slave (
        input  ADJCNT, ADJDIR, BID, CF, CS, DID, F, HD, JESDV, K, L, LID, M, N,
               N_, PHADJ, S, SCR, SUBCLASSV, RES1, RES2, CHKSUM, DI, SYNC_n,
               SYSREF,
        output RDY, DO
    );
endinterface

// File: rtl/jesd204_tx.sv
// -----------------------------------------------------------------------------
// jesd204_tx
// JESD204B single-lane transmit link layer, 4 octets per clock.
// Sends K28.5 code-group sync while the receiver holds SYNC_n low, waits for
// the next LMFC boundary once SYNC_n is released, emits four multiframes of
// ILAS (configuration in the first), then passes DI to DO with one cycle of
// latency. The LMFC word counter free-runs and is re-phased by SYSREF.
// Ports:
//   CLK   : link clock, one 4-octet word per cycle
//   RST_n : asynchronous active-low reset
//   lnk   : configuration, DI/DO, RDY, SYNC_n, SYSREF (slave side)
// DO[0] / DI[0] is the earliest octet in time.
// -----------------------------------------------------------------------------
module jesd204_tx (
    input  logic         CLK,
    input  logic         RST_n,
    jesd204_tx_if.slave  lnk
);
    typedef enum logic [1:0] {ST_CGS, ST_WAIT, ST_ILAS, ST_DATA} state_e;

    localparam logic [7:0] K28_0 = 8'h1C;  // /R/ multiframe start
    localparam logic [7:0] K28_3 = 8'h7C;  // /A/ multiframe end
    localparam logic [7:0] K28_4 = 8'h9C;  // /Q/ config follows
    localparam logic [7:0] K28_5 = 8'hBC;  // /K/ code-group sync

    // Multiframe geometry derived from the ILAS-encoded F and K.
    logic [8:0]  f_plus1;
    logic [5:0]  k_plus1;
    logic [14:0] mf_len;
    logic [14:0] mf_last;
    logic [12:0] p_words;
    logic [12:0] last_word;

    assign f_plus1   = {1'b0, lnk.F} + 9'd1;
    assign k_plus1   = {1'b0, lnk.K} + 6'd1;
    assign mf_len    = {6'd0, f_plus1} * {9'd0, k_plus1};
    assign mf_last   = mf_len - 15'd1;
    assign p_words   = 13'((mf_len + 15'd3) >> 2);
    assign last_word = p_words - 13'd1;

    state_e          state_q, state_d;
    logic [3:0][7:0] do_q, do_d;
    logic            rdy_q, rdy_d;
    logic [12:0]     lmfc_q, lmfc_d;
    logic            sysref_q, sysref_d;
    logic [12:0]     ilas_w_q, ilas_w_d;
    logic [1:0]      ilas_mf_q, ilas_mf_d;

    // ILAS word generator. Outside ILAS the selector points at word 0 of the
    // first multiframe, which is exactly what WAIT emits on the boundary.
    logic [12:0]     w_sel;
    logic            first_mf;
    logic [14:0]     octet_pos;
    logic [3:0][7:0] ilas_word;

    assign w_sel    = (state_q == ST_ILAS) ? ilas_w_q : 13'd0;
    assign first_mf = (state_q != ST_ILAS) || (ilas_mf_q == 2'd0);

    always_comb begin
        ilas_word = '0;
        octet_pos = '0;
        for (int i = 0; i < 4; i++) begin
            octet_pos    = {w_sel, 2'(i)};
            ilas_word[i] = octet_pos[7:0];
            if (octet_pos == 15'd0) begin
                ilas_word[i] = K28_0;
            end else if (octet_pos == mf_last) begin
                ilas_word[i] = K28_3;
            end else if (first_mf && octet_pos == 15'd1) begin
                ilas_word[i] = K28_4;
            end else if (first_mf && octet_pos <= 15'd15) begin
                case (octet_pos[3:0])
                    4'd2:    ilas_word[i] = lnk.DID;
                    4'd3:    ilas_word[i] = {lnk.ADJCNT, lnk.BID};
                    4'd4:    ilas_word[i] = {1'b0, lnk.ADJDIR, lnk.PHADJ, lnk.LID};
                    4'd5:    ilas_word[i] = {lnk.SCR, 2'b00, lnk.L};
                    4'd6:    ilas_word[i] = lnk.F;
                    4'd7:    ilas_word[i] = {3'b000, lnk.K};
                    4'd8:    ilas_word[i] = lnk.M;
                    4'd9:    ilas_word[i] = {lnk.CS, 1'b0, lnk.N};
                    4'd10:   ilas_word[i] = {lnk.SUBCLASSV, lnk.N_};
                    4'd11:   ilas_word[i] = {lnk.JESDV, lnk.S};
                    4'd12:   ilas_word[i] = {lnk.HD, 2'b00, lnk.CF};
                    4'd13:   ilas_word[i] = lnk.RES1;
                    4'd14:   ilas_word[i] = lnk.RES2;
                    4'd15:   ilas_word[i] = lnk.CHKSUM;
                    default: ;
                endcase
            end
        end
    end

    // Next-state logic for the LMFC counter and the link state machine.
    always_comb begin
        // NOTE: every _d gets a default before any branch, so no path can
        // leave one unassigned and infer a latch.
        state_d   = state_q;
        do_d      = {4{K28_5}};
        rdy_d     = 1'b0;
        ilas_w_d  = ilas_w_q;
        ilas_mf_d = ilas_mf_q;
        sysref_d  = lnk.SYSREF;

        // Only a rising SYSREF edge re-phases; a held-high SYSREF does not.
        if (lnk.SYSREF && !sysref_q) begin
            lmfc_d = '0;
        end else if (lmfc_q >= last_word) begin
            lmfc_d = '0;
        end else begin
            lmfc_d = lmfc_q + 13'd1;
        end

        case (state_q)
            ST_CGS: begin
                if (lnk.SYNC_n) state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (!lnk.SYNC_n) begin
                    state_d = ST_CGS;
                end else if (lmfc_q == 13'd0) begin
                    state_d   = ST_ILAS;
                    do_d      = ilas_word;
                    ilas_w_d  = 13'd1;
                    ilas_mf_d = 2'd0;
                end
            end
            ST_ILAS: begin
                if (!lnk.SYNC_n) begin
                    state_d = ST_CGS;
                end else begin
                    do_d = ilas_word;
                    if (ilas_w_q >= last_word) begin
                        ilas_w_d  = 13'd0;
                        ilas_mf_d = ilas_mf_q + 2'd1;
                        if (ilas_mf_q == 2'd3) state_d = ST_DATA;
                    end else begin
                        ilas_w_d = ilas_w_q + 13'd1;
                    end
                end
            end
            ST_DATA: begin
                if (!lnk.SYNC_n) begin
                    state_d = ST_CGS;
                end else begin
                    do_d  = lnk.DI;
                    rdy_d = 1'b1;
                end
            end
            default: state_d = ST_CGS;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            state_q   <= ST_CGS;
            do_q      <= '0;
            rdy_q     <= 1'b0;
            lmfc_q    <= '0;
            sysref_q  <= 1'b0;
            ilas_w_q  <= '0;
            ilas_mf_q <= '0;
        end else begin
            // NOTE: non-blocking so every flop updates from pre-edge values.
            state_q   <= state_d;
            do_q      <= do_d;
            rdy_q     <= rdy_d;
            lmfc_q    <= lmfc_d;
            sysref_q  <= sysref_d;
            ilas_w_q  <= ilas_w_d;
            ilas_mf_q <= ilas_mf_d;
        end
    end

    assign lnk.DO  = do_q;
    assign lnk.RDY = rdy_q;
endmodule

// File: tb/tb_jesd204_tx.sv
// -----------------------------------------------------------------------------
// tb_jesd204_tx
// Directed sequence plus randomized traffic for jesd204_tx. The reference
// model tracks the LMFC phase as (edges since the last SYSREF alignment) mod P,
// builds the whole four-multiframe ILAS as a queue of words from the octet
// rules, and predicts DO/RDY for every clock edge.
// -----------------------------------------------------------------------------
module tb_jesd204_tx;
    logic CLK = 1'b0;
    logic RST_n;

    jesd204_tx_if lnk ();

    jesd204_tx dut (
        .CLK   (CLK),
        .RST_n (RST_n),
        .lnk   (lnk)
    );

    always #5 CLK = ~CLK;

    typedef enum {M_CGS, M_WAIT, M_ILAS, M_DATA} mode_e;

    mode_e       mode;
    int          edge_n;
    int          base_edge;
    logic        prev_sysref;
    logic [31:0] ilas_q [$];
    int          n_cmp;
    int          n_err;

    task automatic check(input string tag, input logic [31:0] act,
                         input logic [31:0] exp);
        n_cmp++;
        assert (act === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, act, exp);
        end
    endtask

    function automatic int mf_octets();
        return (int'(lnk.F) + 1) * (int'(lnk.K) + 1);
    endfunction

    // Whole ILAS as a word queue, built octet by octet from the rules.
    function automatic void build_ilas();
        int          mf;
        logic [7:0]  cfg [14];
        logic [7:0]  oct;
        logic [31:0] w;
        mf      = mf_octets();
        cfg[0]  = lnk.DID;
        cfg[1]  = {lnk.ADJCNT, lnk.BID};
        cfg[2]  = {1'b0, lnk.ADJDIR, lnk.PHADJ, lnk.LID};
        cfg[3]  = {lnk.SCR, 2'b00, lnk.L};
        cfg[4]  = lnk.F;
        cfg[5]  = {3'b000, lnk.K};
        cfg[6]  = lnk.M;
        cfg[7]  = {lnk.CS, 1'b0, lnk.N};
        cfg[8]  = {lnk.SUBCLASSV, lnk.N_};
        cfg[9]  = {lnk.JESDV, lnk.S};
        cfg[10] = {lnk.HD, 2'b00, lnk.CF};
        cfg[11] = lnk.RES1;
        cfg[12] = lnk.RES2;
        cfg[13] = lnk.CHKSUM;
        ilas_q.delete();
        for (int m = 0; m < 4; m++) begin
            for (int o = 0; o < mf; o++) begin
                oct = 8'(o);
                if (o == 0)                         oct = 8'h1C;
                else if (o == mf - 1)               oct = 8'h7C;
                else if (m == 0 && o == 1)          oct = 8'h9C;
                else if (m == 0 && o >= 2 && o <= 15) oct = cfg[o - 2];
                w[8*(o%4) +: 8] = oct;
                if (o % 4 == 3) ilas_q.push_back(w);
            end
        end
    endfunction

    // One clock edge: predict, advance, then compare away from the edge.
    task automatic step(input string tag);
        logic [31:0] exp_do;
        logic        exp_rdy;
        int          ph;
        ph      = (edge_n - 1 - base_edge) % (mf_octets() / 4);
        exp_do  = {4{8'hBC}};
        exp_rdy = 1'b0;
        case (mode)
            M_CGS: if (lnk.SYNC_n) mode = M_WAIT;
            M_WAIT: begin
                if (!lnk.SYNC_n) mode = M_CGS;
                else if (ph == 0) begin
                    build_ilas();
                    exp_do = ilas_q.pop_front();
                    mode   = M_ILAS;
                end
            end
            M_ILAS: begin
                if (!lnk.SYNC_n) mode = M_CGS;
                else begin
                    exp_do = ilas_q.pop_front();
                    if (ilas_q.size() == 0) mode = M_DATA;
                end
            end
            M_DATA: begin
                if (!lnk.SYNC_n) mode = M_CGS;
                else begin
                    exp_do  = lnk.DI;
                    exp_rdy = 1'b1;
                end
            end
            default: mode = M_CGS;
        endcase
        if (lnk.SYSREF && !prev_sysref) base_edge = edge_n;
        prev_sysref = lnk.SYSREF;
        @(posedge CLK);
        edge_n++;
        #1;
        check({tag, "_do"}, lnk.DO, exp_do);
        check({tag, "_rdy"}, 32'(lnk.RDY), 32'(exp_rdy));
    endtask

    task automatic do_reset();
        RST_n      = 1'b0;
        lnk.SYSREF = 1'b0;
        #1;
        check("rst_do", lnk.DO, 32'h0);
        check("rst_rdy", 32'(lnk.RDY), 32'h0);
        repeat (2) @(posedge CLK);
        #1;
        check("rst_hold_do", lnk.DO, 32'h0);
        @(negedge CLK);
        RST_n       = 1'b1;
        mode        = M_CGS;
        edge_n      = 0;
        base_edge   = -1;
        prev_sysref = 1'b0;
        ilas_q.delete();
    endtask

    task automatic set_cfg(input logic [7:0] f, input logic [4:0] k);
        lnk.F         = f;
        lnk.K         = k;
        lnk.ADJCNT    = 4'($urandom);
        lnk.ADJDIR    = 1'($urandom);
        lnk.BID       = 4'($urandom);
        lnk.CF        = 5'($urandom);
        lnk.CS        = 2'($urandom);
        lnk.DID       = 8'($urandom);
        lnk.HD        = 1'($urandom);
        lnk.JESDV     = 3'($urandom);
        lnk.L         = 5'($urandom);
        lnk.LID       = 5'($urandom);
        lnk.M         = 8'($urandom);
        lnk.N         = 5'($urandom);
        lnk.N_        = 5'($urandom);
        lnk.PHADJ     = 1'($urandom);
        lnk.S         = 5'($urandom);
        lnk.SCR       = 1'($urandom);
        lnk.SUBCLASSV = 3'($urandom);
        lnk.RES1      = 8'($urandom);
        lnk.RES2      = 8'($urandom);
        lnk.CHKSUM    = 8'($urandom);
    endtask

    initial begin
        int first_ilas;
        int f;
        int k;
        int mf;

        n_cmp      = 0;
        n_err      = 0;
        RST_n      = 1'b1;
        lnk.SYNC_n = 1'b0;
        lnk.SYSREF = 1'b0;
        lnk.DI     = '0;
        set_cfg(8'd1, 5'd15);  // MF = 32 octets, P = 8 words
        lnk.DID    = 8'h5A;
        lnk.CHKSUM = 8'h3C;
        lnk.ADJCNT = 4'h0;
        lnk.BID    = 4'h3;
        #2;
        do_reset();

        // Code-group sync with the receiver holding SYNC_n low.
        repeat (8) step("cgs");
        check("cgs_const", lnk.DO, 32'hBCBCBCBC);

        // SYSREF at edge 11 puts the next LMFC boundaries at edges 12, 20, ...
        repeat (3) step("pre_sysref");
        lnk.SYSREF = 1'b1;
        step("sysref");
        lnk.SYSREF = 1'b0;
        repeat (2) step("post_sysref");

        // Release SYNC_n at edge 14: ILAS must start at edge 20.
        lnk.SYNC_n = 1'b1;
        first_ilas = -1;
        for (int i = 0; i < 40; i++) begin
            lnk.DI = 32'($urandom);
            step("ilas1");
            if (first_ilas < 0 && lnk.DO !== 32'hBCBCBCBC) begin
                first_ilas = i;
                check("ilas_word0", lnk.DO, 32'h035A9C1C);
            end
        end
        check("ilas_start", 32'(first_ilas), 32'd6);

        lnk.DI = 32'hAA000000;
        step("data_aa");
        check("data_aa_const", lnk.DO, 32'hAA000000);
        check("data_rdy_const", 32'(lnk.RDY), 32'd1);
        for (int i = 0; i < 6; i++) begin
            lnk.DI = 32'($urandom);
            step("data");
        end

        // SYNC_n drop in DATA, then ILAS restart on a later boundary.
        lnk.SYNC_n = 1'b0;
        step("sync_drop");
        check("sync_drop_const", lnk.DO, 32'hBCBCBCBC);
        check("sync_drop_rdy", 32'(lnk.RDY), 32'd0);
        repeat (3) step("cgs2");
        lnk.SYNC_n = 1'b1;
        for (int i = 0; i < 48; i++) begin
            lnk.DI = 32'($urandom);
            step("restart");
        end

        // Re-phase the LMFC mid-multiframe while waiting, and again in ILAS.
        lnk.SYNC_n = 1'b0;
        repeat (3) step("cgs3");
        repeat ($urandom_range(1, 7)) step("gap");
        lnk.SYSREF = 1'b1;
        step("sysref2");
        lnk.SYSREF = 1'b0;
        lnk.SYNC_n = 1'b1;
        for (int i = 0; i < 48; i++) begin
            lnk.DI     = 32'($urandom);
            lnk.SYSREF = (i == 14);
            step("realign");
        end
        lnk.SYSREF = 1'b0;

        // Abort in the middle of ILAS.
        lnk.SYNC_n = 1'b0;
        repeat (2) step("cgs4");
        lnk.SYNC_n = 1'b1;
        repeat (15) step("ilas_part");
        lnk.SYNC_n = 1'b0;
        step("ilas_abort");
        check("ilas_abort_const", lnk.DO, 32'hBCBCBCBC);

        // Asynchronous reset in the middle of traffic.
        lnk.SYNC_n = 1'b1;
        repeat (20) step("pre_rst");
        do_reset();
        lnk.SYNC_n = 1'b0;
        repeat (2) step("post_rst");

        // Random configurations, SYNC_n toggles and SYSREF pulses.
        for (int it = 0; it < 4; it++) begin
            do begin
                f  = $urandom_range(0, 7);
                k  = $urandom_range(0, 31);
                mf = (f + 1) * (k + 1);
            end while (mf % 4 != 0 || mf < 20 || mf > 128);
            set_cfg(8'(f), 5'(k));
            lnk.SYNC_n = 1'b0;
            do_reset();
            for (int c = 0; c < 400; c++) begin
                lnk.DI     = 32'($urandom);
                lnk.SYSREF = ($urandom_range(0, 39) == 0);
                if (c == 5 || $urandom_range(0, 119) == 0) lnk.SYNC_n = ~lnk.SYNC_n;
                step("rnd");
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
